// File: rtl/cordic_sincos.sv
// cordic_sincos: iterative rotation-mode CORDIC that returns cos/sin of a signed
// phase word (2^(DATA_WIDTH-2) = pi/2), one micro-rotation per clock.
// Handshake: start is a one-cycle request honoured only in IDLE (ignored while
// BUSY/FINISH, never queued); done is a one-cycle pulse, and x_out/y_out are valid
// from that cycle on and hold until the next done or reset.
module cordic_sincos #(
    parameter int DATA_WIDTH = 16,
    parameter int ITERATIONS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] angle_in,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  done,
    output logic [1:0]            dbg_state_o
);

    // Two guard bits keep micro-rotation growth from wrapping.
    localparam int IW = DATA_WIDTH + 2;
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    // Constants are stored at 2^30 = pi/2 and rounded down to the working scale.
    localparam int          SH  = 32 - DATA_WIDTH;
    localparam logic [63:0] RND = (64'd1 << SH) >> 1;
    localparam logic [63:0] K30 = 64'd652032874;  // CORDIC gain 0.607253 * 2^30

    localparam logic signed [IW-1:0] X_INIT   = IW'((K30 + RND) >> SH);
    localparam logic signed [IW-1:0] QUARTER  = IW'(64'd1 << (DATA_WIDTH - 2));
    localparam logic signed [IW-1:0] SAT_MAX  = IW'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
    localparam logic signed [IW-1:0] SAT_MIN  = ~SAT_MAX;
    localparam logic [CW-1:0]        LAST_IT  = CW'(ITERATIONS - 1);

    // atan(2^-i) in angle units, rounded from the 2^30 = pi/2 table.
    function automatic logic signed [IW-1:0] atan_lut(input logic [CW-1:0] idx);
        logic [31:0] t;
        logic [63:0] r;
        t = '0;
        case (int'(idx))
            0:  t = 32'h2000_0000;
            1:  t = 32'h12E4_051E;
            2:  t = 32'h09FB_385B;
            3:  t = 32'h0511_11D4;
            4:  t = 32'h028B_0D43;
            5:  t = 32'h0145_D7E1;
            6:  t = 32'h00A2_F61E;
            7:  t = 32'h0051_7C55;
            8:  t = 32'h0028_BE53;
            9:  t = 32'h0014_5F2F;
            10: t = 32'h000A_2F98;
            11: t = 32'h0005_17CC;
            12: t = 32'h0002_8BE6;
            13: t = 32'h0001_45F3;
            14: t = 32'h0000_A2F9;
            15: t = 32'h0000_517C;
            16: t = 32'd10430;
            17: t = 32'd5215;
            18: t = 32'd2608;
            19: t = 32'd1304;
            20: t = 32'd652;
            21: t = 32'd326;
            22: t = 32'd163;
            23: t = 32'd81;
            24: t = 32'd41;
            25: t = 32'd20;
            26: t = 32'd10;
            27: t = 32'd5;
            28: t = 32'd3;
            29: t = 32'd1;
            30: t = 32'd1;
            default: t = 32'd0;
        endcase
        r = ({32'd0, t} + RND) >> SH;
        return IW'(r);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [IW-1:0] v);
        if (v > SAT_MAX)
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (v < SAT_MIN)
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return v[DATA_WIDTH-1:0];
    endfunction

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          iter_q, iter_d;
    logic signed [IW-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic                   neg_q, neg_d;
    logic [DATA_WIDTH-1:0]  x_out_q, x_out_d, y_out_q, y_out_d;
    logic                   done_q, done_d;

    logic signed [IW-1:0]   ang_ext, ang_flip, x_shr, y_shr, atan_cur, x_fin, y_fin;
    logic                   need_flip;

    // Angles beyond +/-90 deg are folded by 180 deg (MSB flip) and the result negated.
    assign ang_ext   = IW'($signed(angle_in));
    assign ang_flip  = IW'($signed({~angle_in[DATA_WIDTH-1], angle_in[DATA_WIDTH-2:0]}));
    assign need_flip = (ang_ext > QUARTER) || (ang_ext < -QUARTER);
    assign x_shr     = x_q >>> iter_q;
    assign y_shr     = y_q >>> iter_q;
    assign atan_cur  = atan_lut(iter_q);
    // Negating at full width before saturation avoids the -2^(W-1) overflow case.
    assign x_fin     = neg_q ? -x_q : x_q;
    assign y_fin     = neg_q ? -y_q : y_q;

    // Next-state logic: load in IDLE, rotate in BUSY, publish in FINISH.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        neg_d   = neg_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    iter_d  = '0;
                    x_d     = X_INIT;
                    y_d     = '0;
                    z_d     = need_flip ? ang_flip : ang_ext;
                    neg_d   = need_flip;
                end
            end
            S_BUSY: begin
                if (!z_q[IW-1]) begin
                    x_d = x_q - y_shr;
                    y_d = y_q + x_shr;
                    z_d = z_q - atan_cur;
                end else begin
                    x_d = x_q + y_shr;
                    y_d = y_q - x_shr;
                    z_d = z_q + atan_cur;
                end
                if (iter_q == LAST_IT)
                    state_d = S_FINISH;
                else
                    iter_d = iter_q + CW'(1);
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                x_out_d = sat(x_fin);
                y_out_d = sat(y_fin);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any computation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            neg_q   <= 1'b0;
            x_out_q <= '0;
            y_out_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            neg_q   <= neg_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            done_q  <= done_d;
        end
    end

    assign x_out       = x_out_q;
    assign y_out       = y_out_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// tb_cordic_sincos: scoreboard bench for cordic_sincos, ideal $cos/$sin reference.
module tb_cordic_sincos;
  localparam int DW   = 16;
  localparam int ITER = 16;
  localparam int TOL  = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] angle_in;
  logic [DW-1:0] x_out;
  logic [DW-1:0] y_out;
  logic          done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_sincos #(.DATA_WIDTH(DW), .ITERATIONS(ITER)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .angle_in    (angle_in),
    .x_out       (x_out),
    .y_out       (y_out),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_x_q[$];
  logic [DW-1:0] exp_y_q[$];
  int            exp_cyc_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  // Ideal value of cos (is_sin=0) or sin (is_sin=1) in Q2.(DW-2), rounded.
  function automatic logic [DW-1:0] ideal(input logic [DW-1:0] a, input bit is_sin);
    real scale, th, v;
    int  r;
    scale = real'(1 << (DW - 2));
    th    = real'(int'($signed(a))) * (3.14159265358979 / 2.0) / scale;
    v     = is_sin ? $sin(th) : $cos(th);
    v     = v * scale;
    r     = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    return r[DW-1:0];
  endfunction

  task automatic check_tol(input string name, input logic [DW-1:0] act,
                           input logic [DW-1:0] expv, input int tol);
    int d;
    d = int'($signed(act)) - int'($signed(expv));
    n_checks++;
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/-%0d (cycle %0d)",
               name, $signed(act), $signed(expv), tol, cyc);
    end
  endtask

  task automatic check_eq(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [DW-1:0] cur_x = '0;
  logic [DW-1:0] cur_y = '0;
  int            cur_tol = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("reset_done", int'(done), 0);
      check_tol("reset_x", x_out, '0, 0);
      check_tol("reset_y", y_out, '0, 0);
      cur_x   = '0;
      cur_y   = '0;
      cur_tol = 0;
    end else begin
      if (done) begin
        if (exp_cyc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_done: done=1 with no outstanding request (cycle %0d)", cyc);
        end else begin
          cur_x   = exp_x_q.pop_front();
          cur_y   = exp_y_q.pop_front();
          cur_tol = TOL;
          check_eq("done_cycle", cyc, exp_cyc_q.pop_front());
        end
      end else if (exp_cyc_q.size() != 0 && cyc >= exp_cyc_q[0]) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_missing: no done by cycle %0d, expected at %0d", cyc, exp_cyc_q[0]);
        void'(exp_x_q.pop_front());
        void'(exp_y_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      // Outputs must carry the latest result (within tolerance) and hold it.
      check_tol("x_out", x_out, cur_x, cur_tol);
      check_tol("y_out", y_out, cur_y, cur_tol);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; pulses start for one cycle.
  task automatic issue(input logic [DW-1:0] a, input bit expect_it);
    start    = 1'b1;
    angle_in = a;
    if (expect_it) begin
      exp_x_q.push_back(ideal(a, 1'b0));
      exp_y_q.push_back(ideal(a, 1'b1));
      exp_cyc_q.push_back(cyc + ITER + 2);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_cyc_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle_timeout: %0d results still outstanding", exp_cyc_q.size());
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done_timeout: done never rose within %0d cycles", n);
    end
  endtask

  // ---------------- stimulus ----------------
  int angles[12] = '{5461, 8192, 10922, 16384, -5461, -16384,
                     21845, -27307, -32768, 16385, -16385, 32767};

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    angle_in = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a computation: no done, outputs cleared.
    issue(DW'(5461), 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_x_q.delete();
    exp_y_q.delete();
    exp_cyc_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (25) @(negedge clk);

    issue(DW'(0), 1'b1);
    wait_idle();

    // Directed angles including quadrant-fold boundaries.
    foreach (angles[i]) begin
      issue(DW'(angles[i]), 1'b1);
      wait_idle();
      repeat (2) @(negedge clk);
    end

    // Starts while busy are ignored.
    issue(DW'(8192), 1'b1);
    repeat (4) @(negedge clk);
    issue(DW'(-27307), 1'b0);
    repeat (3) @(negedge clk);
    issue(DW'(5461), 1'b0);
    wait_idle();

    // Hold after done.
    repeat (10) @(negedge clk);

    // Back-to-back: start in the done cycle.
    issue(DW'(10922), 1'b1);
    wait_done();
    issue(DW'(-5461), 1'b1);
    wait_done();
    issue(DW'(21845), 1'b1);
    wait_idle();

    // Random angles, mixing idle gaps and back-to-back issue.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(DW'($urandom_range(0, 65535)), 1'b1);
      if ($urandom_range(0, 1) == 1)
        wait_done();
      else
        wait_idle();
    end
    wait_idle();
    repeat (5) @(negedge clk);

    check_eq("queue_empty", exp_cyc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
